apb_initiator: RTL

Bus-side APB4 initiator that turns a single-outstanding valid/ready request into a compliant SETUP/ACCESS transfer and returns the completion on a valid/ready response channel. It sits between a core-side load/store unit and the APB fabric, directly upstream of the APB delayer or any APB completer. A programmable ACCESS-phase timeout aborts hung transfers so the core never deadlocks on a silent peripheral.

---
 rtl/apb_pkg.sv | 17 +
 rtl/apb_initiator.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/apb_pkg.sv
// Shared APB definitions: transfer state encoding and bus field widths,
// common to the initiator, delayer and completers.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;
  localparam int APB_PROT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

endpackage : apb_pkg

// File: rtl/apb_initiator.sv
// APB4 initiator: one outstanding valid/ready request becomes a SETUP/ACCESS
// transfer; the completion (or an ACCESS-phase timeout) returns on the response channel.
module apb_initiator
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clock,
  input  logic                  reset,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [APB_ADDR_W-1:0] req_addr,
  input  logic                  req_write,
  input  logic [APB_DATA_W-1:0] req_wdata,
  input  logic [APB_STRB_W-1:0] req_strb,
  input  logic [APB_PROT_W-1:0] req_prot,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,

  output logic [APB_ADDR_W-1:0] paddr,
  output logic [APB_PROT_W-1:0] pprot,
  output logic                  pwrite,
  output logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_STRB_W-1:0] pstrb,
  output logic                  psel,
  output logic                  penable,
  input  logic                  pready,
  input  logic [APB_DATA_W-1:0] prdata,
  input  logic                  pslverr
);

  // A zero TIMEOUT still needs a 1-bit counter so the declarations stay legal.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [APB_ADDR_W-1:0] paddr_q, paddr_d;
  logic [APB_PROT_W-1:0] pprot_q, pprot_d;
  logic                  pwrite_q, pwrite_d;
  logic [APB_DATA_W-1:0] pwdata_q, pwdata_d;
  logic [APB_STRB_W-1:0] pstrb_q, pstrb_d;
  logic [APB_DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pprot_d       = pprot_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    pstrb_d       = pstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          paddr_d  = req_addr;
          pprot_d  = req_prot;
          pwrite_d = req_write;
          pwdata_d = req_wdata;
          pstrb_d  = req_write ? req_strb : '0;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        // A completion in the final allowed cycle beats the timeout.
        if (pready) begin
          rsp_rdata_d   = pwrite_q ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          state_d       = RESP;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pprot_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      pstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      pprot_q       <= pprot_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      pstrb_q       <= pstrb_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  // Phase controls decode straight from the state register; any unknown
  // encoding decodes to all-deasserted.
  assign req_ready   = (state_q == IDLE);
  assign psel        = (state_q == SETUP) || (state_q == ACCESS);
  assign penable     = (state_q == ACCESS);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign paddr       = paddr_q;
  assign pprot       = pprot_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign pstrb       = pstrb_q;

endmodule : apb_initiator
